// File: rtl/vector_lsu_if.sv
// OBI-style data memory port: the LSU drives it as master, memory answers as slave.
interface vector_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_gnt;
    logic [ADDR_W-1:0] data_addr;
    logic              data_we;
    logic [3:0]        data_be;
    logic [31:0]       data_wdata;
    logic              data_rvalid;
    logic [31:0]       data_rdata;
    logic              data_err;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store unit: walks vl byte elements (unit-stride words or strided bytes) over the data port.
// One transaction outstanding; request held stable until grant, loads written back one registered cycle after rvalid.
module vector_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vlsu_en,
    input  logic              vlsu_load,
    input  logic              vlsu_store,
    input  logic              vlsu_strided,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       stride,
    input  logic [4:0]        vl,
    input  logic [4:0]        vreg_base,
    output logic              vlsu_ready,
    output logic              lsu_error,
    output logic              vreg_wr_en,
    output logic [4:0]        vreg_wr_addr,
    output logic [31:0]       vreg_wr_data,
    output logic [3:0]        vreg_wr_be,
    output logic [4:0]        vreg_rd_addr,
    input  logic [31:0]       vreg_rd_data,
    vector_lsu_if.master      mem
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, WB, DONE} state_e;

    state_e            state_q;
    logic              en_q;
    logic              load_q;
    logic              strided_q;
    logic [31:0]       stride_q;
    logic [4:0]        vl_q;
    logic [4:0]        vbase_q;
    logic [4:0]        elem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [31:0]       buf_q;
    logic [3:0]        buf_be_q;
    logic              wr_en_q;
    logic [4:0]        wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [3:0]        wr_be_q;

    logic [4:0]        word_idx;
    logic [4:0]        remain;
    logic [3:0]        acc_be;
    logic              last;
    logic              flush;
    logic              in_req;
    logic [7:0]        st_byte;
    logic [7:0]        ld_byte;
    logic [ADDR_W-1:0] stride_ext;
    logic [ADDR_W-1:0] addr_d;
    logic [4:0]        elem_d;
    logic [31:0]       buf_d;
    logic [3:0]        buf_be_d;

    // Unit-stride keeps elem_idx a multiple of 4, so the word index is always elem_idx>>2.
    assign word_idx   = {2'b00, elem_q[4:2]};
    assign remain     = vl_q - elem_q;
    assign stride_ext = ADDR_W'($signed(stride_q));
    assign last       = ({1'b0, elem_q} + (strided_q ? 6'd1 : 6'd4)) >= {1'b0, vl_q};
    assign flush      = (elem_q[1:0] == 2'd3) || last;
    assign st_byte    = 8'(vreg_rd_data >> {elem_q[1:0], 3'b000});
    assign ld_byte    = 8'(mem.data_rdata >> {addr_q[1:0], 3'b000});
    assign addr_d     = addr_q + (strided_q ? stride_ext : ADDR_W'(4));
    assign elem_d     = elem_q + (strided_q ? 5'd1 : 5'd4);

    always_comb begin
        acc_be = 4'hF;
        if (strided_q) begin
            acc_be = 4'b0001 << addr_q[1:0];
        end else if (remain < 5'd4) begin
            acc_be = (4'b0001 << remain[1:0]) - 4'd1;
        end
    end

    always_comb begin
        buf_d = buf_q;
        buf_d[{elem_q[1:0], 3'b000} +: 8] = ld_byte;
        buf_be_d = buf_be_q | (4'b0001 << elem_q[1:0]);
    end

    // Bus outputs are pure decodes of registered state, so they cannot move during a grant stall.
    assign in_req         = (state_q == REQ);
    assign mem.data_req   = in_req;
    assign mem.data_addr  = in_req ? addr_q : '0;
    assign mem.data_we    = in_req & ~load_q;
    assign mem.data_be    = in_req ? acc_be : 4'h0;
    assign mem.data_wdata = (in_req && !load_q) ? (strided_q ? {4{st_byte}} : vreg_rd_data) : 32'h0;
    assign vreg_rd_addr   = vbase_q + word_idx;
    assign vlsu_ready     = (state_q == DONE);
    assign lsu_error      = err_q;
    assign vreg_wr_en     = wr_en_q;
    assign vreg_wr_addr   = wr_addr_q;
    assign vreg_wr_data   = wr_data_q;
    assign vreg_wr_be     = wr_be_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            load_q    <= 1'b0;
            strided_q <= 1'b0;
            stride_q  <= '0;
            vl_q      <= '0;
            vbase_q   <= '0;
            elem_q    <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            buf_q     <= '0;
            buf_be_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            en_q      <= vlsu_en;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (vlsu_en && !en_q) begin
                        load_q    <= vlsu_load & ~vlsu_store;
                        strided_q <= vlsu_strided;
                        stride_q  <= stride;
                        vl_q      <= vl;
                        vbase_q   <= vreg_base;
                        elem_q    <= '0;
                        addr_q    <= base_addr;
                        err_q     <= 1'b0;
                        buf_q     <= '0;
                        buf_be_q  <= '0;
                        if (vl == 5'd0) begin
                            state_q <= DONE;
                        end else if (!vlsu_strided && base_addr[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem.data_gnt) state_q <= RESP;
                end
                RESP: begin
                    if (mem.data_rvalid) begin
                        if (mem.data_err) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (!load_q) begin
                            elem_q  <= elem_d;
                            addr_q  <= addr_d;
                            state_q <= last ? DONE : REQ;
                        end else begin
                            state_q <= WB;
                            if (!strided_q) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= vbase_q + word_idx;
                                wr_data_q <= mem.data_rdata;
                                wr_be_q   <= acc_be;
                            end else if (flush) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= vbase_q + word_idx;
                                wr_data_q <= buf_d;
                                wr_be_q   <= buf_be_d;
                                buf_q     <= '0;
                                buf_be_q  <= '0;
                            end else begin
                                buf_q    <= buf_d;
                                buf_be_q <= buf_be_d;
                            end
                        end
                    end
                end
                WB: begin
                    elem_q  <= elem_d;
                    addr_q  <= addr_d;
                    state_q <= last ? DONE : REQ;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store unit sitting directly downstream of the vector decoder. It accepts a load or store command (`vlsu_en`/`vlsu_load`/`vlsu_store`/`vlsu_strided`), walks `vl` 8-bit elements over an OBI-style data memory port, and writes loaded words into the vector register file or reads register words for stores. It signals completion through `vlsu_ready`. SEW is fixed at 8 bits, with 4 elements per 32-bit vector register.

## Interface
- `ADDR_W`, default 32: memory address width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vlsu_en`  in  1  command valid; held high by the decoder while the instruction executes.
- `vlsu_load`, `vlsu_store`  in  1  direction; exactly one is high with `vlsu_en`.
- `vlsu_strided`  in  1  selects strided mode; 0 selects unit-stride.
- `base_addr`  in  ADDR_W  scalar base address (rs1).
- `stride`  in  32  byte stride (rs2), two's complement; used only in strided mode.
- `vl`  in  5  element count, 0..16.
- `vreg_base`  in  5  first vector register (vd for loads, vs3 for stores).
- `vlsu_ready`  out  1  one-cycle completion pulse.
- `lsu_error`  out  1  sticky error flag; cleared at the next start.
- `vreg_wr_en`  out  1  register write strobe.
- `vreg_wr_addr`  out  5  register write address.
- `vreg_wr_data`  out  32  register write data.
- `vreg_wr_be`  out  4  register write byte enables.
- `vreg_rd_addr`  out  5  store-data read address.
- `vreg_rd_data`  in  32  store-data read value; combinational, valid the same cycle.
- `data_req`  out  1  memory request.
- `data_gnt`  in  1  memory grant.
- `data_addr`  out  ADDR_W  memory address.
- `data_we`  out  1  memory write enable.
- `data_be`  out  4  memory byte enables.
- `data_wdata`  out  32  memory write data.
- `data_rvalid`  in  1  memory response valid.
- `data_rdata`  in  32  memory read data.
- `data_err`  in  1  memory error; qualified by `data_rvalid`.

## Operation
- **States.** IDLE, REQ, RESP, WB, DONE.
- **Start.** A start occurs on IDLE & `vlsu_en` & ~`vlsu_en_q`, i.e. on the rising edge of `vlsu_en`.
  - All command inputs are captured.
  - `lsu_error` is cleared.
  - `elem_idx` and `word_idx` are reset to 0.
  - `cur_addr` is loaded with `base_addr`.
- **Start exits from IDLE.**
  - `vl`==0: go straight to DONE with no memory traffic.
  - Unit-stride with `base_addr[1:0]`!=0: set `lsu_error` and go to DONE with no traffic.
  - Otherwise go to REQ.
- **Unit-stride transfers.**
  - One word access per register; `data_addr` = `cur_addr`.
  - `data_be` = first min(4, vl−4·`word_idx`) byte lanes.
  - After each word: `cur_addr` += 4, `word_idx` += 1, `elem_idx` += 4.
- **Strided transfers.**
  - One byte access per element; `data_addr` = `cur_addr`.
  - `data_be` = 1<<`cur_addr[1:0]`.
  - After each element: `cur_addr` += `stride`, with wrap-around modulo 2^ADDR_W. `elem_idx` += 1.
  - Loads: the byte from lane `cur_addr[1:0]` is placed into assembly buffer byte `elem_idx[1:0]`.
- **REQ.** `data_req`=1 with address, `be`, `we` and `wdata` held stable until `data_gnt`. On `data_gnt` go to RESP. Only one transaction is ever outstanding.
- **Store data.**
  - `vreg_rd_addr` = `vreg_base` + `word_idx`, where `word_idx` = `elem_idx`>>2 in strided mode.
  - Unit-stride: `data_wdata` = `vreg_rd_data`.
  - Strided: `data_wdata` = the selected byte replicated across all 4 lanes.
- **RESP.** Waits for `data_rvalid`.
  - `data_err`=1: set `lsu_error` and go to DONE, abandoning the remaining elements.
  - Store, no error: if the last element is done go to DONE, else go to REQ.
  - Load, no error: latch the data and go to WB.
- **WB** (load only; one cycle). `vreg_wr_addr` = `vreg_base` + `word_idx`.
  - Unit-stride: `vreg_wr_en`=1, `vreg_wr_be` = the access `data_be`.
  - Strided: `vreg_wr_en` fires only when `elem_idx[1:0]`==3 or on the last element. `vreg_wr_be` covers the bytes filled in the current register. The buffer clears after each write.
  - Next state: DONE if this was the last element, else REQ.
- **DONE.** `vlsu_ready`=1 for exactly one cycle, then IDLE.
- **`vlsu_en` drop.** A fall of `vlsu_en` mid-operation is ignored; the operation completes.
- **Reset values.** All outputs are 0 and the state is IDLE. Reset asserted mid-operation drops `data_req` asynchronously. A response arriving after reset is ignored.

## Timing
- Unit-stride with grant in the request cycle: a load word costs REQ → RESP (≥1 cycle) → WB, i.e. ≥3 cycles; a store word costs ≥2 cycles.
- `vlsu_ready` fires the cycle after the final WB (load) or the final RESP (store).
- `vl`=0 and the misaligned-base error path both give `vlsu_ready` 2 cycles after start.
- Register writes are registered: `vreg_wr_*` are valid in the WB cycle only.
- `data_rvalid` in the same cycle as `data_req` is illegal (protocol minimum is one cycle after grant).

## Test plan
1. **Unit-stride load.** `vl`=6, `base_addr`=0x100, memory words 0x44332211 and 0x88776655. Expect v`base` write 0x44332211 with `be`=1111, v`base`+1 write with `be`=0011, then one `vlsu_ready` pulse.
2. **Strided load.** `vl`=5, `base_addr`=0x203, `stride`=−1. Expect addresses 0x203…0x1FF with `data_be` 1000, 0100, 0010, 0001, 1000. Expect a full-word write, then a `be`=0001 write to `vreg_base`+1.
3. **Unit-stride store with grant stall.** `vl`=4, `data_gnt` delayed 3 cycles. `data_req`, `data_addr` and `data_wdata` must stay stable for the stall; exactly one write with `be`=1111.
4. **Error path.** `data_err` on the 2nd word of a `vl`=12 load. Expect `lsu_error`=1, no further requests, `vlsu_ready` pulsed; `lsu_error` clears on the next start.
5. **Boundary cases.** `vl`=0 gives `vlsu_ready` at start+2 with no traffic. Misaligned unit-stride base 0x101 gives `lsu_error`. Holding `vlsu_en` high across DONE does not restart the unit.
6. **Reset mid-operation.** Assert `reset` during REQ. `data_req` drops immediately, all outputs return to 0, and a subsequent command works normally.
